// File: rtl/cavlc_nc_pkg.sv
// Shared definitions for the CAVLC nC context block.
//   - TotalCoeff block type encoding (luma, Cb AC, Cr AC).
//   - Layout of one 36-bit top-row line-buffer entry.
//   - Controller FSM state encoding.
//   - Helper that saturates a chroma TC to the 4-bit RAM field.
package cavlc_nc_pkg;

  typedef enum logic [1:0] {
    TcLuma = 2'd0,
    TcCb   = 2'd1,
    TcCr   = 2'd2,
    TcRsvd = 2'd3
  } tc_type_e;

  // Line-buffer entry: {Cr c1, Cr c0, Cb c1, Cb c0, luma c3, c2, c1, c0}.
  localparam int unsigned RamW    = 36;
  localparam int unsigned LumaW   = 5;
  localparam int unsigned ChromaW = 4;
  localparam int unsigned LumaLsb = 0;
  localparam int unsigned CbLsb   = 20;
  localparam int unsigned CrLsb   = 28;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRdTop = 3'd1,
    StLdTop = 3'd2,
    StReady = 3'd3,
    StWb    = 3'd4
  } state_e;

  function automatic logic [ChromaW-1:0] sat_chroma(input logic [LumaW-1:0] v);
    return (v > 5'd15) ? 4'd15 : v[ChromaW-1:0];
  endfunction

endpackage

// File: rtl/cavlc_nc_calc.sv
// Combinational nC computation from the two neighbour TotalCoeff values.
//   na, nb            : left / top neighbour TC
//   avail_a, avail_b  : neighbour availability
//   nc                : (na+nb+1)>>1 if both, the available one if one, else 0
module cavlc_nc_calc #(
  parameter int unsigned TC_W = 5
) (
  input  logic [TC_W-1:0] na,
  input  logic [TC_W-1:0] nb,
  input  logic            avail_a,
  input  logic            avail_b,
  output logic [TC_W-1:0] nc
);

  // One extra bit so 16+16+1 does not wrap before the shift.
  logic [TC_W:0] sum;

  always_comb begin
    sum = {1'b0, na} + {1'b0, nb} + {{TC_W{1'b0}}, 1'b1};
    case ({avail_a, avail_b})
      2'b11:   nc = sum[TC_W:1];
      2'b10:   nc = na;
      2'b01:   nc = nb;
      default: nc = '0;
    endcase
  end

endmodule

// File: rtl/cavlc_nc_ctrl.sv
// CAVLC nC context controller for one macroblock at a time.
// Holds the current MB's TotalCoeff values, the left-neighbour column and the
// top-neighbour row, and drives the top-row line buffer RAM.
//   clk, rst_n             : clock, asynchronous active-low reset
//   mb_start, mb_x, mb_y   : start a new MB (accepted in idle only)
//   mb_done                : begin write-back of the MB bottom row (ready only)
//   tc_we/type/idx/val     : store one block TotalCoeff (ready only)
//   nc_req/type/idx        : request nC for a block (ready only)
//   nc_valid, nc_val       : registered nC result, one cycle after nc_req
//   ready                  : top neighbours loaded
//   ram_rd, ram_raddr      : line-buffer read at MB start
//   ram_rdata              : read data, one cycle after ram_rd
//   ram_we, ram_waddr/wdata: line-buffer write-back at MB end
module cavlc_nc_ctrl
  import cavlc_nc_pkg::*;
#(
  parameter int unsigned MB_X_W = 7,
  parameter int unsigned MB_Y_W = 8,
  parameter int unsigned TC_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mb_start,
  input  logic [MB_X_W-1:0] mb_x,
  input  logic [MB_Y_W-1:0] mb_y,
  input  logic              mb_done,
  input  logic              tc_we,
  input  logic [1:0]        tc_type,
  input  logic [3:0]        tc_idx,
  input  logic [TC_W-1:0]   tc_val,
  input  logic              nc_req,
  input  logic [1:0]        nc_type,
  input  logic [3:0]        nc_idx,
  output logic              nc_valid,
  output logic [TC_W-1:0]   nc_val,
  output logic              ready,
  output logic              ram_rd,
  output logic [MB_X_W-1:0] ram_raddr,
  input  logic [RamW-1:0]   ram_rdata,
  output logic              ram_we,
  output logic [MB_X_W-1:0] ram_waddr,
  output logic [RamW-1:0]   ram_wdata
);

  state_e state_q, state_d;
  logic [MB_X_W-1:0] mb_x_q;
  logic [MB_Y_W-1:0] mb_y_q;

  // Current MB TC arrays, indexed {row,col}.
  logic [TC_W-1:0] luma_q [16];
  logic [TC_W-1:0] cb_q   [4];
  logic [TC_W-1:0] cr_q   [4];

  // Right column of the previous MB, indexed by row.
  logic [TC_W-1:0] left_luma_q [4];
  logic [TC_W-1:0] left_cb_q   [2];
  logic [TC_W-1:0] left_cr_q   [2];

  // Bottom row of the MB above, indexed by column.
  logic [LumaW-1:0]   top_luma_q [4];
  logic [ChromaW-1:0] top_cb_q   [2];
  logic [ChromaW-1:0] top_cr_q   [2];

  logic     tc_fire, nc_fire, left_avail, top_avail;
  tc_type_e tc_kind, nc_kind;

  assign tc_kind    = tc_type_e'(tc_type);
  assign nc_kind    = tc_type_e'(nc_type);
  assign left_avail = (mb_x_q != '0);
  assign top_avail  = (mb_y_q != '0);
  assign ready      = (state_q == StReady);
  assign nc_fire    = nc_req && ready;
  // Chroma blocks only exist at idx 0..3; anything else is dropped.
  assign tc_fire    = tc_we && ready && (tc_kind == TcLuma || tc_idx[3:2] == 2'd0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (mb_start) state_d = StRdTop;
      StRdTop: state_d = StLdTop;
      StLdTop: state_d = StReady;
      StReady: if (mb_done) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mb_x_q  <= '0;
      mb_y_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && mb_start) begin
        mb_x_q <= mb_x;
        mb_y_q <= mb_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Current MB TC storage; cleared during write-back for the next MB.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) luma_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        cb_q[i] <= '0;
        cr_q[i] <= '0;
      end
    end else if (state_q == StWb) begin
      for (int i = 0; i < 16; i++) luma_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        cb_q[i] <= '0;
        cr_q[i] <= '0;
      end
    end else if (tc_fire) begin
      unique case (tc_kind)
        TcLuma:  luma_q[tc_idx]    <= tc_val;
        TcCb:    cb_q[tc_idx[1:0]] <= tc_val;
        TcCr:    cr_q[tc_idx[1:0]] <= tc_val;
        default: ;
      endcase
    end
  end

  // Left column: right column of this MB, taken at write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) left_luma_q[r] <= '0;
      for (int r = 0; r < 2; r++) begin
        left_cb_q[r] <= '0;
        left_cr_q[r] <= '0;
      end
    end else if (state_q == StWb) begin
      for (int r = 0; r < 4; r++) left_luma_q[r] <= luma_q[4*r+3];
      for (int r = 0; r < 2; r++) begin
        left_cb_q[r] <= cb_q[2*r+1];
        left_cr_q[r] <= cr_q[2*r+1];
      end
    end
  end

  // Top row: unpacked from the line buffer one cycle after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) top_luma_q[c] <= '0;
      for (int c = 0; c < 2; c++) begin
        top_cb_q[c] <= '0;
        top_cr_q[c] <= '0;
      end
    end else if (state_q == StLdTop) begin
      for (int c = 0; c < 4; c++) top_luma_q[c] <= ram_rdata[LumaLsb + c*LumaW +: LumaW];
      for (int c = 0; c < 2; c++) begin
        top_cb_q[c] <= ram_rdata[CbLsb + c*ChromaW +: ChromaW];
        top_cr_q[c] <= ram_rdata[CrLsb + c*ChromaW +: ChromaW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Neighbour selection
  // ---------------------------------------------------------------------------
  logic [TC_W-1:0]    ch_cur  [4];
  logic [TC_W-1:0]    ch_left [2];
  logic [ChromaW-1:0] ch_top  [2];
  logic [TC_W-1:0]    na, nb, nc_calc;
  logic               avail_a, avail_b;

  always_comb begin
    ch_cur  = cb_q;
    ch_left = left_cb_q;
    ch_top  = top_cb_q;
    if (nc_kind == TcCr) begin
      ch_cur  = cr_q;
      ch_left = left_cr_q;
      ch_top  = top_cr_q;
    end
    na      = '0;
    nb      = '0;
    avail_a = 1'b0;
    avail_b = 1'b0;
    unique case (nc_kind)
      TcLuma: begin
        if (nc_idx[1:0] != 2'd0) begin
          na      = luma_q[nc_idx - 4'd1];
          avail_a = 1'b1;
        end else begin
          na      = left_luma_q[nc_idx[3:2]];
          avail_a = left_avail;
        end
        if (nc_idx[3:2] != 2'd0) begin
          nb      = luma_q[nc_idx - 4'd4];
          avail_b = 1'b1;
        end else begin
          nb      = TC_W'(top_luma_q[nc_idx[1:0]]);
          avail_b = top_avail;
        end
      end
      TcCb, TcCr: begin
        // Out-of-range chroma idx leaves both unavailable, giving nC = 0.
        if (nc_idx[3:2] == 2'd0) begin
          if (nc_idx[0]) begin
            na      = ch_cur[nc_idx[1:0] - 2'd1];
            avail_a = 1'b1;
          end else begin
            na      = ch_left[nc_idx[1]];
            avail_a = left_avail;
          end
          if (nc_idx[1]) begin
            nb      = ch_cur[nc_idx[1:0] - 2'd2];
            avail_b = 1'b1;
          end else begin
            nb      = TC_W'(ch_top[nc_idx[0]]);
            avail_b = top_avail;
          end
        end
      end
      default: ;
    endcase
  end

  cavlc_nc_calc #(
    .TC_W (TC_W)
  ) u_calc (
    .na      (na),
    .nb      (nb),
    .avail_a (avail_a),
    .avail_b (avail_b),
    .nc      (nc_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nc_valid <= 1'b0;
      nc_val   <= '0;
    end else begin
      nc_valid <= nc_fire;
      nc_val   <= nc_fire ? nc_calc : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Line-buffer interface
  // ---------------------------------------------------------------------------
  logic [RamW-1:0] wb_data;

  always_comb begin
    wb_data = '0;
    for (int c = 0; c < 4; c++) wb_data[LumaLsb + c*LumaW +: LumaW] = luma_q[12+c];
    for (int c = 0; c < 2; c++) begin
      wb_data[CbLsb + c*ChromaW +: ChromaW] = sat_chroma(cb_q[2+c]);
      wb_data[CrLsb + c*ChromaW +: ChromaW] = sat_chroma(cr_q[2+c]);
    end
  end

  assign ram_rd    = (state_q == StRdTop);
  assign ram_raddr = mb_x_q;
  assign ram_we    = (state_q == StWb);
  assign ram_waddr = mb_x_q;
  assign ram_wdata = ram_we ? wb_data : '0;

endmodule
